// File: rtl/sc_frogcheck.sv
// Frog game referee: watches the frog's row for collisions or nest arrival and
// sequences lives, nests and frog repositioning through a Moore FSM.
module sc_frogcheck #(
  parameter int         DATAWIDTH   = 8,
  parameter logic [1:0] LIVES_INIT  = 2'd3,
  parameter logic [2:0] NESTS_TOTAL = 3'd4,
  parameter logic [2:0] TOP_LEVEL   = 3'd7,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic                 SC_FROGCHECK_CLOCK_50,
  input  logic                 SC_FROGCHECK_RESET_InHigh,
  input  logic                 SC_FROGCHECK_start_InLow,
  input  logic [DATAWIDTH-1:0] SC_FROGCHECK_frogrow_InBUS,
  input  logic [DATAWIDTH-1:0] SC_FROGCHECK_obstaclerow_InBUS,
  input  logic [2:0]           SC_FROGCHECK_froglevel_InBUS,
  output logic                 SC_FROGCHECK_collision_OutLow,
  output logic                 SC_FROGCHECK_nest_reached_OutLow,
  output logic                 SC_FROGCHECK_frog_reset_OutLow,
  output logic [1:0]           SC_FROGCHECK_lives_OutBUS,
  output logic [2:0]           SC_FROGCHECK_nests_OutBUS,
  output logic                 SC_FROGCHECK_gameover_OutHigh,
  output logic                 SC_FROGCHECK_win_OutHigh,
  output logic [2:0]           SC_FROGCHECK_state_OutBUS
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    HIT     = 3'd2,
    NEST    = 3'd3,
    RESPAWN = 3'd4,
    OVER    = 3'd5,
    WIN     = 3'd6
  } state_t;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     stateNext;
  logic [1:0] livesReg;
  logic [2:0] nestsReg;
  logic [3:0] holdCnt;
  logic       overlap;
  logic       atTop;

  // An empty frog row can never overlap, so no explicit frogrow==0 guard is needed.
  assign overlap = |(SC_FROGCHECK_frogrow_InBUS & SC_FROGCHECK_obstaclerow_InBUS);
  assign atTop   = (SC_FROGCHECK_froglevel_InBUS == TOP_LEVEL);

  always_ff @(posedge SC_FROGCHECK_CLOCK_50 or posedge SC_FROGCHECK_RESET_InHigh) begin
    if (SC_FROGCHECK_RESET_InHigh) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, OVER, WIN: begin
        if (!SC_FROGCHECK_start_InLow) stateNext = RESPAWN;
      end
      PLAY: begin
        if (overlap)    stateNext = HIT;
        else if (atTop) stateNext = NEST;
      end
      HIT:     stateNext = (livesReg == 2'd0) ? OVER : RESPAWN;
      NEST:    stateNext = (nestsReg == NESTS_TOTAL) ? WIN : RESPAWN;
      RESPAWN: begin
        if (holdCnt == 4'd0) stateNext = PLAY;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Counters change on the same edge that enters HIT/NEST, so those states
  // already see the updated lives/nests when choosing OVER/WIN.
  always_ff @(posedge SC_FROGCHECK_CLOCK_50 or posedge SC_FROGCHECK_RESET_InHigh) begin
    if (SC_FROGCHECK_RESET_InHigh) begin
      livesReg <= '0;
      nestsReg <= '0;
      holdCnt  <= '0;
    end else begin
      case (state)
        IDLE, OVER, WIN: begin
          if (!SC_FROGCHECK_start_InLow) begin
            livesReg <= LIVES_INIT;
            nestsReg <= '0;
            holdCnt  <= HOLD_RELOAD;
          end
        end
        PLAY: begin
          if (overlap) begin
            if (livesReg != 2'd0) livesReg <= livesReg - 2'd1;
          end else if (atTop) begin
            if (nestsReg != NESTS_TOTAL) nestsReg <= nestsReg + 3'd1;
          end
        end
        HIT, NEST: holdCnt <= HOLD_RELOAD;
        RESPAWN: begin
          if (holdCnt != 4'd0) holdCnt <= holdCnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SC_FROGCHECK_collision_OutLow    = (state != HIT);
    SC_FROGCHECK_nest_reached_OutLow = (state != NEST);
    SC_FROGCHECK_frog_reset_OutLow   = (state != RESPAWN);
    SC_FROGCHECK_gameover_OutHigh    = (state == OVER) || (state == WIN);
    SC_FROGCHECK_win_OutHigh         = (state == WIN);
    SC_FROGCHECK_state_OutBUS        = state;
    SC_FROGCHECK_lives_OutBUS        = livesReg;
    SC_FROGCHECK_nests_OutBUS        = nestsReg;
  end

endmodule

// File: tb/tb_sc_frogcheck.sv
// Scoreboard bench for sc_frogcheck: stimulus queues expected pulse/respawn/end
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_sc_frogcheck;

  localparam int EV_COL  = 1;
  localparam int EV_NEST = 2;
  localparam int EV_RESP = 3;
  localparam int EV_GO   = 4;

  typedef struct {
    int kind;
    int len;
    int lives;
    int nests;
    int state;
    int win;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic [7:0] frog = '0;
  logic [7:0] obst = '0;
  logic [2:0] lev = '0;
  logic       col, nest, frst, go, win;
  logic [1:0] lives;
  logic [2:0] nests;
  logic [2:0] st;

  ev_t sb[$];
  int  nTests = 0;
  int  nFail  = 0;
  int  lowCnt = 0;
  logic prevGo = 1'b0;

  sc_frogcheck #(
    .DATAWIDTH(8), .LIVES_INIT(2'd3), .NESTS_TOTAL(3'd4), .TOP_LEVEL(3'd7), .HOLD_CYCLES(4)
  ) dut (
    .SC_FROGCHECK_CLOCK_50(clk),
    .SC_FROGCHECK_RESET_InHigh(rst),
    .SC_FROGCHECK_start_InLow(start),
    .SC_FROGCHECK_frogrow_InBUS(frog),
    .SC_FROGCHECK_obstaclerow_InBUS(obst),
    .SC_FROGCHECK_froglevel_InBUS(lev),
    .SC_FROGCHECK_collision_OutLow(col),
    .SC_FROGCHECK_nest_reached_OutLow(nest),
    .SC_FROGCHECK_frog_reset_OutLow(frst),
    .SC_FROGCHECK_lives_OutBUS(lives),
    .SC_FROGCHECK_nests_OutBUS(nests),
    .SC_FROGCHECK_gameover_OutHigh(go),
    .SC_FROGCHECK_win_OutHigh(win),
    .SC_FROGCHECK_state_OutBUS(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int len, input int lv, input int ns,
                      input int s, input int w);
    ev_t e;
    e.kind = kind; e.len = len; e.lives = lv; e.nests = ns; e.state = s; e.win = w;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input int len);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", kind, 0);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_lives", int'(lives), e.lives);
      check("event_nests", int'(nests), e.nests);
      check("event_state", int'(st), e.state);
      if (kind == EV_RESP) check("respawn_len", len, e.len);
      if (kind == EV_GO)   check("win_flag", int'(win), e.win);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      lowCnt = 0;
      prevGo = 1'b0;
    end else begin
      if (!col)  observe(EV_COL, 0);
      if (!nest) observe(EV_NEST, 0);
      if (!frst) lowCnt++;
      else if (lowCnt != 0) begin
        observe(EV_RESP, lowCnt);
        lowCnt = 0;
      end
      if (go && !prevGo) observe(EV_GO, 0);
      prevGo = go;
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic pulseStart();
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
  endtask

  task automatic apply(input logic [7:0] f, input logic [7:0] o, input logic [2:0] l);
    @(negedge clk); frog = f; obst = o; lev = l;
    @(negedge clk); frog = '0; obst = '0; lev = '0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_state"}, int'(st), 0);
    check({tag, "_lives"}, int'(lives), 0);
    check({tag, "_nests"}, int'(nests), 0);
    check({tag, "_col"}, int'(col), 1);
    check({tag, "_nest"}, int'(nest), 1);
    check({tag, "_frst"}, int'(frst), 1);
    check({tag, "_go"}, int'(go), 0);
    check({tag, "_win"}, int'(win), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", int'(st), 0);

    // start: 4-cycle respawn, then PLAY with 3 lives
    push(EV_RESP, 4, 3, 0, 1, 0);
    pulseStart();
    drain(20);

    // empty frog row never collides; start ignored while playing
    @(negedge clk); frog = '0; obst = 8'hFF; lev = 3'd3;
    repeat (3) @(negedge clk);
    obst = '0; lev = '0;
    check("nofrog_state", int'(st), 1);
    check("nofrog_lives", int'(lives), 3);
    pulseStart();
    @(negedge clk);
    check("start_ignored_state", int'(st), 1);

    // single collision
    push(EV_COL, 0, 2, 0, 2, 0);
    push(EV_RESP, 4, 2, 0, 1, 0);
    apply(8'h10, 8'h18, 3'd3);
    drain(20);

    // overlap at the top row must be a hit, not a nest
    push(EV_COL, 0, 1, 0, 2, 0);
    push(EV_RESP, 4, 1, 0, 1, 0);
    apply(8'h04, 8'h04, 3'd7);
    drain(20);
    check("overlap_top_nests", int'(nests), 0);

    // four nests -> WIN
    for (int n = 1; n <= 4; n++) begin
      push(EV_NEST, 0, 1, n, 3, 0);
      if (n < 4) push(EV_RESP, 4, 1, n, 1, 0);
      else       push(EV_GO, 0, 1, 4, 6, 1);
      apply(8'h01, 8'h02, 3'd7);
      drain(20);
    end
    check("win_gameover", int'(go), 1);

    // restart from WIN, then lose all lives
    push(EV_RESP, 4, 3, 0, 1, 0);
    pulseStart();
    drain(20);
    for (int k = 2; k >= 0; k--) begin
      push(EV_COL, 0, k, 0, 2, 0);
      if (k > 0) push(EV_RESP, 4, k, 0, 1, 0);
      else       push(EV_GO, 0, 0, 0, 5, 0);
      apply(8'h80, 8'hC0, 3'd2);
      drain(20);
    end
    apply(8'hFF, 8'hFF, 3'd7);
    repeat (3) @(negedge clk);
    check("over_frozen_state", int'(st), 5);
    check("over_frozen_lives", int'(lives), 0);
    check("over_win", int'(win), 0);

    push(EV_RESP, 4, 3, 0, 1, 0);
    pulseStart();
    drain(20);
    check("restart_lives", int'(lives), 3);

    // reset in the second respawn cycle
    push(EV_COL, 0, 2, 0, 2, 0);
    apply(8'h08, 8'h08, 3'd1);
    begin
      int i;
      for (i = 0; i < 10 && frst; i++) @(negedge clk);
      check("respawn_seen", int'(frst), 0);
    end
    @(negedge clk);
    check("respawn_cycle2", int'(frst), 0);
    #2 rst = 1'b1;
    #1 checkResetOutputs("midreset");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("postreset");
    check("leftover_events", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/sc_frogcheck.md
SC_FROGCHECK -- requirements
Module: SC_FROGCHECK

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the width of the row bitmaps.
REQ-002 The block SHALL have parameter LIVES_INIT, default 2'd3, giving the lives loaded at game start (range 1..3).
REQ-003 The block SHALL have parameter NESTS_TOTAL, default 3'd4, giving the nests needed to win (range 1..7).
REQ-004 The block SHALL have parameter TOP_LEVEL, default 3'd7, giving the frog level index of the nest row.
REQ-005 The block SHALL have parameter HOLD_CYCLES, default 4, giving the frog_reset low duration (range 1..15).
REQ-006 SC_FROGCHECK_CLOCK_50  in  1  single system clock; all state updates on rising edge.
REQ-007 SC_FROGCHECK_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-008 SC_FROGCHECK_start_InLow  in  1  active-low start/restart request.
REQ-009 SC_FROGCHECK_frogrow_InBUS  in  DATAWIDTH  frog bitmap in the row the frog occupies.
REQ-010 SC_FROGCHECK_obstaclerow_InBUS  in  DATAWIDTH  obstacle/point-type bitmap of that same row.
REQ-011 SC_FROGCHECK_froglevel_InBUS  in  3  row index of the frog (0 = start row).
REQ-012 SC_FROGCHECK_collision_OutLow  out  1  active-low one-cycle collision pulse to the row registers.
REQ-013 SC_FROGCHECK_nest_reached_OutLow  out  1  active-low one-cycle nest pulse to the row registers.
REQ-014 SC_FROGCHECK_frog_reset_OutLow  out  1  active-low frog reposition request.
REQ-015 SC_FROGCHECK_lives_OutBUS  out  2  remaining lives.
REQ-016 SC_FROGCHECK_nests_OutBUS  out  3  nests reached.
REQ-017 SC_FROGCHECK_gameover_OutHigh  out  1  high in OVER or WIN.
REQ-018 SC_FROGCHECK_win_OutHigh  out  1  high in WIN only.
REQ-019 SC_FROGCHECK_state_OutBUS  out  3  current state code.

Function
REQ-020 The block SHALL implement a Moore FSM: IDLE=0, PLAY=1, HIT=2, NEST=3, RESPAWN=4, OVER=5, WIN=6; codes 7 SHALL return to IDLE next cycle.
REQ-021 In IDLE, start_InLow=0 SHALL load lives=LIVES_INIT, nests=0, hold counter=HOLD_CYCLES-1 and go to RESPAWN.
REQ-022 In PLAY, (frogrow AND obstaclerow)!=0 SHALL go to HIT and decrement lives on the same edge.
REQ-023 In PLAY, with no overlap and froglevel==TOP_LEVEL, the FSM SHALL go to NEST and increment nests on the same edge.
REQ-024 Overlap SHALL take priority over nest when both hold in the same cycle; frogrow==0 SHALL never cause a collision.
REQ-025 HIT SHALL last exactly one cycle with collision_OutLow=0, then go to OVER if lives==0, else RESPAWN with hold counter reloaded.
REQ-026 NEST SHALL last exactly one cycle with nest_reached_OutLow=0, then go to WIN if nests==NESTS_TOTAL, else RESPAWN with hold counter reloaded.
REQ-027 RESPAWN SHALL drive frog_reset_OutLow=0 for exactly HOLD_CYCLES cycles (down-counter to 0), then go to PLAY.
REQ-028 OVER and WIN SHALL hold lives/nests frozen until start_InLow=0, which SHALL restart as in REQ-021.
REQ-029 Lives SHALL never underflow and nests SHALL never exceed NESTS_TOTAL.
REQ-030 start_InLow SHALL be ignored in PLAY, HIT, NEST and RESPAWN.
REQ-031 All outputs SHALL be decoded from registered state/counters only; no combinational input-to-output path.

Reset
REQ-032 Reset SHALL force, at any time including mid-RESPAWN: state=IDLE, lives=0, nests=0, hold counter=0.
REQ-033 During and after reset, the block SHALL drive collision/nest/frog_reset=1, gameover=0, win=0.

Verification
REQ-034 Start pulse from IDLE -> frog_reset_OutLow low exactly 4 cycles, then state=1, lives=3, nests=0.
REQ-035 PLAY with frogrow=8'h10, obstaclerow=8'h18 -> one-cycle collision_OutLow low, lives 3->2, then RESPAWN of 4 cycles.
REQ-036 Overlap together with froglevel=7 -> HIT, not NEST; nests unchanged.
REQ-037 Four nest arrivals (level 7, no overlap) -> four nest pulses, nests=4, state=6, gameover=1, win=1.
REQ-038 Three collisions -> lives=0, state=5, gameover=1, win=0; start_InLow low -> restart with lives=3.
REQ-039 Reset asserted during RESPAWN cycle 2 -> immediate IDLE, all pulses high, counters 0.
